// File: rtl/apolo_tx_system.sv
// APOLO transmitter top: repeatedly sends "APOLO\r\n" as 8N1 UART frames with an idle gap,
// toggling led once per complete message. uart_rxd is synchronised only.
module apolo_tx_system #(
  parameter int clk_freq       = 100000000,
  parameter int uart_baud_rate = 115200,
  parameter int gap_cycles     = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic led,
  input  logic uart_rxd,
  output logic uart_txd
);

  localparam int unsigned DIV  = clk_freq / uart_baud_rate;
  localparam int unsigned CMAX = (DIV > gap_cycles) ? DIV : gap_cycles;
  localparam int unsigned CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {
    IDLE_WAIT,
    SEND,
    DONE
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt,   w_cnt_nxt;
  logic [3:0]    r_bit,   w_bit_nxt;
  logic [2:0]    r_idx,   w_idx_nxt;
  logic          r_txd,   w_txd_nxt;
  logic          r_led,   w_led_nxt;
  logic          r_first, w_first_nxt;
  logic [1:0]    r_rxd_sync;

  logic [7:0]    w_byte;
  logic [CW-1:0] w_limit;
  logic          w_bit_end;
  logic          w_rxd_unused;

  function automatic logic [7:0] rom_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    rom_byte = 8'h41;
      3'd1:    rom_byte = 8'h50;
      3'd2:    rom_byte = 8'h4F;
      3'd3:    rom_byte = 8'h4C;
      3'd4:    rom_byte = 8'h4F;
      3'd5:    rom_byte = 8'h0D;
      3'd6:    rom_byte = 8'h0A;
      default: rom_byte = 8'hFF;
    endcase
  endfunction

  // Receive line is synchronised for board compatibility and otherwise ignored
  always_ff @(posedge clk) begin
    if (rst) r_rxd_sync <= '1;
    else     r_rxd_sync <= {r_rxd_sync[0], uart_rxd};
  end
  assign w_rxd_unused = r_rxd_sync[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE_WAIT;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_idx   <= '0;
      r_txd   <= 1'b1;
      r_led   <= 1'b0;
      r_first <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_idx   <= w_idx_nxt;
      r_txd   <= w_txd_nxt;
      r_led   <= w_led_nxt;
      r_first <= w_first_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_idx_nxt   = r_idx;
    w_txd_nxt   = r_txd;
    w_led_nxt   = r_led;
    w_first_nxt = r_first;

    w_byte    = rom_byte(r_idx);
    w_bit_end = (r_cnt == CW'(DIV - 1));
    w_limit   = r_first ? CW'(DIV) : CW'(gap_cycles);

    case (r_state)
      IDLE_WAIT: begin
        w_txd_nxt = 1'b1;
        if (r_cnt == w_limit) begin
          w_state_nxt = SEND;
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          w_idx_nxt   = '0;
          w_txd_nxt   = 1'b0;
          w_first_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end

      SEND: begin
        if (!w_bit_end) begin
          w_cnt_nxt = r_cnt + CW'(1);
        end else begin
          w_cnt_nxt = '0;
          if (r_bit == 4'd9) begin
            if (r_idx == 3'd6) begin
              w_state_nxt = DONE;
              w_txd_nxt   = 1'b1;
              w_led_nxt   = ~r_led;
              // The DONE cycle is the first idle cycle of the gap
              w_cnt_nxt   = CW'(1);
            end else begin
              w_idx_nxt = r_idx + 3'd1;
              w_bit_nxt = '0;
              w_txd_nxt = 1'b0;
            end
          end else begin
            w_bit_nxt = r_bit + 4'd1;
            // Bit r_bit+1 is data bit r_bit for 0..7, stop bit for 8
            w_txd_nxt = (r_bit == 4'd8) ? 1'b1 : w_byte[r_bit[2:0]];
          end
        end
      end

      DONE: begin
        w_txd_nxt   = 1'b1;
        w_cnt_nxt   = r_cnt + CW'(1);
        w_state_nxt = IDLE_WAIT;
      end

      default: begin
        w_state_nxt = IDLE_WAIT;
        w_cnt_nxt   = '0;
        w_txd_nxt   = 1'b1;
      end
    endcase
  end

  assign uart_txd = r_txd;
  assign led      = r_led;

endmodule

// File: tb/tb_apolo_tx_system.sv
// Bench for apolo_tx_system: every cycle compares uart_txd/led against a timeline model
// derived from message period arithmetic, with random rxd noise and random resets.
module tb_apolo_tx_system;

  localparam int CLK_FREQ = 100000000;
  localparam int BAUD     = 1152000;
  localparam int GAP      = 1000;
  localparam int DIV      = CLK_FREQ / BAUD;
  localparam int FRAME    = 10 * DIV;
  localparam int MSG      = 7 * FRAME;
  localparam int PERIOD   = MSG + GAP;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic uart_rxd;
  logic led;
  logic uart_txd;

  int n_vec = 0;
  int n_err = 0;
  int k     = -1;
  int t;

  logic [7:0] text [7] = '{8'h41, 8'h50, 8'h4F, 8'h4C, 8'h4F, 8'h0D, 8'h0A};

  always #5 clk = ~clk;

  apolo_tx_system #(
    .clk_freq      (CLK_FREQ),
    .uart_baud_rate(BAUD),
    .gap_cycles    (GAP)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .led     (led),
    .uart_rxd(uart_rxd),
    .uart_txd(uart_txd)
  );

  // Line level after edge kk, counting edge 0 as the first edge with rst low
  function automatic logic exp_txd(input int kk);
    int p, f, b;
    logic [7:0] c;
    if (kk < DIV) return 1'b1;
    p = (kk - DIV) % PERIOD;
    if (p >= MSG) return 1'b1;
    f = p / FRAME;
    b = (p % FRAME) / DIV;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    c = text[f];
    return c[b-1];
  endfunction

  function automatic logic exp_led(input int kk);
    int n;
    if (kk < DIV + MSG) return 1'b0;
    n = (kk - DIV - MSG) / PERIOD + 1;
    return n[0];
  endfunction

  task automatic step();
    logic was;
    logic et, el;
    case ($urandom_range(0, 2))
      0:       uart_rxd = 1'bz;
      1:       uart_rxd = 1'b0;
      default: uart_rxd = 1'b1;
    endcase
    was = rst;
    @(posedge clk);
    #1;
    if (was) begin
      et = 1'b1;
      el = 1'b0;
    end else begin
      k++;
      et = exp_txd(k);
      el = exp_led(k);
    end
    n_vec++;
    assert (uart_txd === et) else begin
      n_err++;
      $error("FAIL txd k=%0d rst=%b got %b want %b", k, was, uart_txd, et);
    end
    n_vec++;
    assert (led === el) else begin
      n_err++;
      $error("FAIL led k=%0d rst=%b got %b want %b", k, was, led, el);
    end
  endtask

  initial begin
    uart_rxd = 1'bz;
    rst      = 1'b1;
    repeat (4) step();

    rst = 1'b0;
    k   = -1;
    repeat (DIV + 2 * PERIOD + 50) step();

    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    k   = -1;
    // Land the reset inside the data bits of 'L' in the second message (led high)
    t = DIV + PERIOD + 3 * FRAME + DIV + int'($urandom_range(0, 8 * DIV - 1));
    while (k < t) step();
    rst = 1'b1;
    repeat ($urandom_range(1, 4)) step();
    rst = 1'b0;
    k   = -1;
    repeat (DIV + PERIOD + 200) step();

    repeat (3) begin
      repeat ($urandom_range(50, PERIOD)) step();
      rst = 1'b1;
      repeat ($urandom_range(1, 3)) step();
      rst = 1'b0;
      k   = -1;
    end
    repeat (DIV + PERIOD + 10) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/apolo_tx_system.md
Name:
apolo_tx_system

Overview:
- Top-level of the APOLO transmitter FPGA design.
- Repeatedly sends the fixed ASCII message "APOLO\r\n" over a UART transmit line (8N1), with an idle gap between messages.
- Toggles a status LED after each complete message.
- UART receive input is present for board compatibility only; it is synchronised and otherwise ignored.

Parameters:
- clk_freq, 100000000, system clock frequency in Hz.
- uart_baud_rate, 115200, UART bit rate in bit/s. Simulation benches override this to 1152000.
- gap_cycles, 1000, idle clock cycles (txd held high) between the end of one message's stop bit and the next message's start bit.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- led  output  1  message-complete indicator; toggles once per transmitted message.
- uart_rxd  input  1  UART receive line. Passed through a 2-FF synchroniser, otherwise unused. X/Z on this pin must never propagate to any output.
- uart_txd  output  1  UART transmit line; idle high.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high via rst. While rst=1 on a clock edge, all state is cleared.
- Reset values: uart_txd=1, led=0, sequencer in IDLE_WAIT, byte index=0, bit counter=0, baud counter=0.
- Bit period DIV = clk_freq / uart_baud_rate, integer-truncated (100 MHz / 1152000 -> 86 cycles). Every bit, including start and stop, lasts exactly DIV cycles.
- Frame format: start bit 0, then 8 data bits LSB first, then 1 stop bit (1). 10*DIV cycles per byte. No parity.
- Message ROM, 7 bytes, in order:
  - 0x41 'A'
  - 0x50 'P'
  - 0x4F 'O'
  - 0x4C 'L'
  - 0x4F 'O'
  - 0x0D CR
  - 0x0A LF
- Sequencer states:
  - IDLE_WAIT: txd=1, count cycles. After DIV cycles following reset release, or gap_cycles after a message ends, load byte index 0 and go to SEND.
  - SEND: the transmitter shifts out ROM[index]. Bytes are sent back-to-back: the next start bit begins the cycle after the previous stop bit's last cycle.
  - DONE: after the stop bit of byte 6 completes, toggle led (single cycle), reset the gap counter, return to IDLE_WAIT.
- First start bit falls on the clock edge DIV cycles after the first edge with rst=0.
- Message period = 70*DIV + gap_cycles cycles. With bench values this is 6020 + 1000 = 7020 cycles.
- Reset asserted mid-frame: on the next edge txd returns high and led returns to 0. The message restarts from 'A' after the post-reset DIV wait. No partial byte is resumed.
- The transmitter never emits glitches: uart_txd is driven directly from a register.
- Byte index wraps 6 -> 0 only via DONE/IDLE_WAIT, never mid-message.

Test Plan:
- Reset: hold rst=1 for 4 cycles -> uart_txd=1, led=0 throughout; uart_rxd left floating (Z) -> outputs never X.
- First frame (clk_freq=100e6, baud=1152000): release rst -> txd falls 86 cycles later. Then sample mid-bit every 86 cycles -> 0, then 1,0,0,0,0,0,1,0 (0x41 LSB first), then stop 1.
- Full message: decode 7 consecutive frames -> 0x41,0x50,0x4F,0x4C,0x4F,0x0D,0x0A, no idle cycles between frames.
- LED and gap: led toggles 0->1 one cycle after the last stop bit of 0x0A (cycle 86+6020 after reset release). txd stays high exactly 1000 cycles, then the next 'A' start bit. led toggles 1->0 after the second message.
- Reset mid-operation: assert rst during the data bits of byte 'L' -> next edge txd=1, led=0. After release, the stream restarts with 'A' after 86 cycles.
- Long run of 500000 cycles -> 71 complete messages, each period exactly 7020 cycles, led toggling once per message.
